mmc3_scanline_irq: RTL
======================

# mmc3_scanline_irq

Scanline interrupt unit for MMC3-class mappers (004, 118 and derivatives) in the CoolGirl multicart. It sits beside the mapper register block. It snoops CPU writes to $C000–$FFFF and the PPU A12 line, and counts filtered A12 rising edges (one per rendered scanline). When the count expires it drives the cartridge IRQ line low, and the top level routes that line to `irq`. All logic runs in the M2 domain, so no PPU-side clock is needed.

## Interface
Parameters:
- `A12_LOW_CYCLES`, default 3: number of consecutive M2 samples with A12 low that must precede a rise before it counts as a scanline clock (range 1–7).

Ports:
- `m2`  in  1  CPU M2; the sole clock; all state updates on the falling edge of m2.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1  mapper selects MMC3 IRQ; 0 = unit idle.
- `romsel`  in  1  active-low $8000–$FFFF select.
- `cpu_rw_in`  in  1  1 = read, 0 = write.
- `cpu_addr_in`  in  15  CPU A14..A0.
- `cpu_data_in`  in  8  CPU data bus (input-only view).
- `ppu_a12`  in  1  PPU A12, asynchronous to m2.
- `alt_irq`  in  1  0 = revision B behaviour, 1 = revision A behaviour.
- `irq`  out  1  0 when an interrupt is pending; 1'bZ otherwise (open-drain).
- `irq_counter`  out  8  current counter value, for debug and verification.

## Operation
- A CPU write is recognised on an m2 falling edge with romsel=0 and cpu_rw_in=0. Decode uses {A14,A13,A0}:
  - 100 = $C000: latch ← data.
  - 101 = $C001: counter ← 0, reload ← 1.
  - 110 = $E000: irq_en ← 0, pending ← 0.
  - 111 = $E001: irq_en ← 1.
  - $8000–$BFFF: ignored.
- A12 path:
  - Two-flop synchronizer produces s2.
  - `low_cnt` is 3 bits and saturates at A12_LOW_CYCLES. It increments while s2=0 and clears while s2=1.
  - Scanline clock fires on the edge where s2 first reads 1 (previous s2=0) and low_cnt == A12_LOW_CYCLES.
- Scanline clock:
  - If counter==0 or reload=1: counter ← latch and reload ← 0.
  - Otherwise: counter ← counter−1.
- IRQ trigger: the new counter is 0 and irq_en=1, and additionally one of:
  - alt_irq=0: always.
  - alt_irq=1: the old counter was nonzero or reload was 1.
  - On trigger, pending ← 1.
- Pending is cleared only by a $E000 write, by enable=0, or by reset.
- `irq` = pending ? 0 : Z.
- enable=0:
  - latch, counter, reload and irq_en hold their values; CPU writes are ignored.
  - Scanline clocks are discarded; pending is forced to 0.
  - The synchronizer and low_cnt keep running.
- Arithmetic is 8-bit with no wrap: decrement never occurs from 0, because 0 always reloads.

## Timing
- Reset values: latch=0, counter=0, reload=0, irq_en=0, pending=0, low_cnt=0, sync flops=0, irq=Z, irq_counter=0.
- Reset asserted mid-count clears everything immediately, without waiting for an edge.
- Write latency: register state changes on the same m2 falling edge that samples the write. `irq` releases on that edge for $E000.
- A12 latency: with A12 rising before m2 falling edge k, s2=1 at edge k+1. The counter and pending update at edge k+1; `irq` goes to 0 after edge k+1.
- A12 pulses shorter than one m2 period may be missed; this is acceptable.
- A12 high-to-high gaps shorter than A12_LOW_CYCLES samples produce no clock (this filters the 8 sprite fetches).
- Simultaneous events on the same edge:
  - $C001 write + scanline clock: the write wins (counter=0, reload=1) and the clock is dropped.
  - $C000 write + clock: the clock uses the old latch.
  - $E000 write + trigger: pending ends at 0.
  - $E001 write + clock: the trigger uses the old irq_en.
- A pending IRQ persists across any number of further clocks until it is acknowledged.

## Test plan
- Reset, then 10 A12 pulses (low 8 m2, high 2 m2) with enable=1 and no writes -> irq stays Z, irq_counter=0.
- $C000←3, $C001, $E001, then A12 pulses -> counter sequence 3,2,1,0; irq=0 one edge after the 4th synchronized rise; $E000 write -> irq=Z on that edge.
- Latch=0, irq_en=1, alt_irq=0, 3 pulses -> irq asserts after each pulse (acknowledge between pulses). Same with alt_irq=1 -> irq asserts only after the first pulse following $C001.
- A12 pulses separated by 2 low samples with A12_LOW_CYCLES=3 -> counter unchanged; separation of 3 samples -> decrement.
- $C001 write on the same edge as a scanline clock with counter=5 -> counter=0, reload=1; next pulse loads latch.
- Pending irq, then enable←0 -> irq=Z; enable←1 with counter=2 -> counter still 2, and A12 pulses resume counting.

Source files
------------

// File: rtl/mmc3_scanline_irq.sv
// MMC3-class scanline IRQ: snoops $C000-$FFFF writes, filters PPU A12 rises
// into scanline clocks and drives an open-drain IRQ when the counter expires.
module mmc3_scanline_irq #(
    parameter int A12_LOW_CYCLES = 3
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        ppu_a12,
    input  logic        alt_irq,
    output logic        irq,
    output logic [7:0]  irq_counter
);

    localparam logic [2:0] LOW_MAX = 3'(A12_LOW_CYCLES);

    logic       r_s1;
    logic       r_s2;
    logic [2:0] r_low_cnt;
    logic [7:0] r_latch;
    logic [7:0] r_counter;
    logic       r_reload;
    logic       r_irq_en;
    logic       r_pending;

    logic       w_wr;
    logic       w_wr_c000;
    logic       w_wr_c001;
    logic       w_wr_e000;
    logic       w_wr_e001;
    logic       w_a12_clk;
    logic       w_clk;
    logic       w_reload_now;
    logic [7:0] w_cnt_next;
    logic       w_trigger;

    // Writes are only decoded while the unit is enabled; $8000-$BFFF has A14=0.
    assign w_wr      = enable & ~romsel & ~cpu_rw_in & cpu_addr_in[14];
    assign w_wr_c000 = w_wr & ~cpu_addr_in[13] & ~cpu_addr_in[0];
    assign w_wr_c001 = w_wr & ~cpu_addr_in[13] &  cpu_addr_in[0];
    assign w_wr_e000 = w_wr &  cpu_addr_in[13] & ~cpu_addr_in[0];
    assign w_wr_e001 = w_wr &  cpu_addr_in[13] &  cpu_addr_in[0];

    // r_s1 is the value s2 takes on this edge, so low_cnt counts s2 low samples.
    assign w_a12_clk    = r_s1 & ~r_s2 & (r_low_cnt == LOW_MAX);
    assign w_clk        = w_a12_clk & enable & ~w_wr_c001;
    assign w_reload_now = (r_counter == 8'd0) | r_reload;
    assign w_cnt_next   = w_reload_now ? r_latch : (r_counter - 8'd1);
    assign w_trigger    = w_clk & (w_cnt_next == 8'd0) & r_irq_en &
                          (~alt_irq | (r_counter != 8'd0) | r_reload);

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_low_cnt <= 3'd0;
        end else begin
            r_s1 <= ppu_a12;
            r_s2 <= r_s1;
            if (r_s1)
                r_low_cnt <= 3'd0;
            else if (r_low_cnt != LOW_MAX)
                r_low_cnt <= r_low_cnt + 3'd1;
        end
    end

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_latch   <= 8'd0;
            r_counter <= 8'd0;
            r_reload  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (w_wr_c000)
                r_latch <= cpu_data_in;

            if (w_wr_c001) begin
                r_counter <= 8'd0;
                r_reload  <= 1'b1;
            end else if (w_clk) begin
                r_counter <= w_cnt_next;
                r_reload  <= 1'b0;
            end

            if (w_wr_e000)
                r_irq_en <= 1'b0;
            else if (w_wr_e001)
                r_irq_en <= 1'b1;

            if (!enable || w_wr_e000)
                r_pending <= 1'b0;
            else if (w_trigger)
                r_pending <= 1'b1;
        end
    end

    assign irq         = r_pending ? 1'b0 : 1'bz;
    assign irq_counter = r_counter;

endmodule
